// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencing for the 5-stage RV32 pipeline: load-use interlock,
// branch squash, data-memory wait with timeout and multi-cycle multiply hold.
module pipeline_ctrl #(
    parameter int MUL_LAT     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RS1D,
    input  logic [4:0] RS2D,
    input  logic [4:0] RDE,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       MulStartE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic       MemErr
);

    typedef enum logic [1:0] {RUN, MEMWAIT, MULBUSY} state_t;

    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] L_MUL_END = CNT_W'(MUL_LAT - 1);
    localparam logic             L_MUL_MC  = (MUL_LAT > 1);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_memerr, w_set_err;
    logic             w_mem_stall, w_mul_stall, w_br_flush, w_lu_stall;
    logic             w_mem_miss, w_load_use;

    assign w_mem_miss = MemReqM && !MemReadyM;
    assign w_load_use = ResultSrcE0 && (RDE != 5'd0) && ((RDE == RS1D) || (RDE == RS2D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_memerr <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_nxt;
            if (w_set_err) r_memerr <= 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_cnt;
        w_set_err   = 1'b0;
        w_mem_stall = 1'b0;
        w_mul_stall = 1'b0;
        w_br_flush  = 1'b0;
        w_lu_stall  = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_miss) begin
                    w_mem_stall = 1'b1;
                    w_next      = MEMWAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (MulStartE && L_MUL_MC) begin
                    w_mul_stall = 1'b1;
                    w_next      = MULBUSY;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (PCSrcE) begin
                    w_br_flush = 1'b1;
                end else if (w_load_use) begin
                    w_lu_stall = 1'b1;
                end
            end
            MEMWAIT: begin
                if (MemReadyM) begin
                    w_next    = RUN;
                    w_cnt_nxt = '0;
                end else if (r_cnt == L_TIMEOUT) begin
                    // forced release; the access is abandoned and flagged
                    w_set_err = 1'b1;
                    w_next    = RUN;
                    w_cnt_nxt = '0;
                end else begin
                    w_mem_stall = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            MULBUSY: begin
                if (r_cnt == L_MUL_END) begin
                    w_next    = RUN;
                    w_cnt_nxt = '0;
                end else begin
                    w_mul_stall = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next    = RUN;
                w_cnt_nxt = '0;
            end
        endcase
    end

    // reset gates the Mealy outputs so they drop the instant rst falls
    assign StallF = rst && (w_mem_stall || w_mul_stall || w_lu_stall);
    assign StallD = rst && (w_mem_stall || w_mul_stall || w_lu_stall);
    assign StallE = rst && (w_mem_stall || w_mul_stall);
    assign StallM = rst && w_mem_stall;
    assign FlushD = rst && w_br_flush;
    assign FlushE = rst && (w_br_flush || w_lu_stall);
    assign FlushM = rst && w_mul_stall;
    assign FlushW = rst && w_mem_stall;
    assign MemErr = r_memerr;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table of RUN-state vectors plus
// hand-written memory-wait, timeout, multiply, priority and reset sequences.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] RS1D, RS2D, RDE;
    logic       ResultSrcE0, PCSrcE, MulStartE, MemReqM, MemReadyM;

    logic sF0, sD0, sE0, sM0, fD0, fE0, fM0, fW0, err0;
    logic sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1, err1;
    logic [8:0] o0, o1;
    assign o0 = {sF0, sD0, sE0, sM0, fD0, fE0, fM0, fW0, err0};
    assign o1 = {sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1, err1};

    // output word: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,MemErr}
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] LU   = 9'b110001000;
    localparam logic [8:0] BR   = 9'b000011000;
    localparam logic [8:0] MEM  = 9'b111100010;
    localparam logic [8:0] MUL  = 9'b111000100;
    localparam logic [8:0] ERR  = 9'b000000001;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MUL_LAT(4), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RDE(RDE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(sF0), .StallD(sD0), .StallE(sE0), .StallM(sM0),
        .FlushD(fD0), .FlushE(fE0), .FlushM(fM0), .FlushW(fW0), .MemErr(err0)
    );

    pipeline_ctrl #(.MUL_LAT(1), .MEM_TIMEOUT(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .RS1D(RS1D), .RS2D(RS2D), .RDE(RDE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(sF1), .StallD(sD1), .StallE(sE1), .StallM(sM1),
        .FlushD(fD1), .FlushE(fE1), .FlushM(fM1), .FlushW(fW1), .MemErr(err1)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rde;
        logic       ld, br, mreq, mrdy;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        RS1D = 0; RS2D = 0; RDE = 0;
        ResultSrcE0 = 0; PCSrcE = 0; MulStartE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        //            rs1    rs2    rde    ld  br  mreq mrdy exp
        tbl[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE};
        tbl[1] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU};
        tbl[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE};
        tbl[3] = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU};
        tbl[4] = '{5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, NONE};
        tbl[5] = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NONE};
        tbl[6] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR};
        tbl[7] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BR};
        tbl[8] = '{5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, LU};
        tbl[9] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR};

        // reset with a live load-use hazard on the inputs: outputs must stay 0
        rst = 1'b0;
        clr();
        RS1D = 5'd5; RDE = 5'd5; ResultSrcE0 = 1'b1;
        #1 chk("reset_out", o0, NONE);
        chk("reset_out_mul1", o1, NONE);
        tick();
        rst = 1'b1;
        clr();
        #1 chk("after_reset", o0, NONE);

        foreach (tbl[i]) begin
            RS1D = tbl[i].rs1; RS2D = tbl[i].rs2; RDE = tbl[i].rde;
            ResultSrcE0 = tbl[i].ld; PCSrcE = tbl[i].br;
            MemReqM = tbl[i].mreq; MemReadyM = tbl[i].mrdy;
            #1 chk($sformatf("vec%0d", i), o0, tbl[i].exp);
            tick();
        end
        clr();
        #1 chk("lu_one_cycle_only", o0, NONE);

        // memory handshake: 3 not-ready cycles then ready; branch ignored while frozen
        tick();
        MemReqM = 1'b1;
        for (int c = 0; c < 3; c++) begin
            PCSrcE = (c == 1);
            #1 chk($sformatf("mem_wait%0d", c), o0, MEM);
            tick();
        end
        PCSrcE = 1'b0;
        MemReadyM = 1'b1;
        #1 chk("mem_ready", o0, NONE);
        tick();
        clr();
        #1 chk("mem_after", o0, NONE);

        // timeout: 4 frozen cycles, forced release on the 5th, sticky MemErr
        tick();
        MemReqM = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("to_wait%0d", c), o0, MEM);
            tick();
        end
        #1 chk("to_release", o0, NONE);
        tick();
        clr();
        #1 chk("to_err_set", o0, ERR);
        tick(); tick();
        RS2D = 5'd4; RDE = 5'd4; ResultSrcE0 = 1'b1;
        #1 chk("to_err_sticky_lu", o0, LU | ERR);
        tick();
        clr();
        rst = 1'b0;
        #1 chk("to_err_cleared", o0, NONE);
        tick();
        rst = 1'b1;
        #1 chk("to_err_stays_clear", o0, NONE);

        // multiply: 3 stall cycles with MUL_LAT=4, none with MUL_LAT=1
        tick();
        MulStartE = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("mul_busy%0d", c), o0, MUL);
            chk($sformatf("mul1_none%0d", c), o1, NONE);
            tick();
        end
        #1 chk("mul_release", o0, NONE);
        chk("mul1_release", o1, NONE);
        tick();
        clr();
        #1 chk("mul_after", o0, NONE);

        // priority: memory miss beats multiply, multiply runs after release
        tick();
        MemReqM = 1'b1; MulStartE = 1'b1;
        #1 chk("prio_mem_first", o0, MEM);
        tick();
        #1 chk("prio_mem_hold", o0, MEM);
        tick();
        MemReadyM = 1'b1;
        #1 chk("prio_mem_ready", o0, NONE);
        tick();
        MemReqM = 1'b0; MemReadyM = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("prio_mul%0d", c), o0, MUL);
            tick();
        end
        #1 chk("prio_mul_release", o0, NONE);
        tick();
        // MulStartE still high: a second multiply starts in the first RUN cycle
        #1 chk("b2b_mul_start", o0, MUL);
        tick();
        #1 chk("b2b_mul_busy", o0, MUL);
        rst = 1'b0;
        #1 chk("rst_mid_mul_async", o0, NONE);
        tick();
        rst = 1'b1;
        MulStartE = 1'b0;
        PCSrcE = 1'b1;
        #1 chk("rst_state_run", o0, BR);
        tick();
        clr();
        #1 chk("final_idle", o0, NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
